rf_write_arbiter: RTL and testbench

Shares the single register-file write port (we3/wa3/wd3) between two producers: requester A (ALU writeback) and requester B (memory-load writeback). Each requester has a one-entry holding buffer with a valid/ready handshake. Arbitration is age-ordered with round-robin tie-break, and writes to r0 are absorbed without consuming the port. A hazard query port lets decode stall logic test whether a write to a given register is still pending.

---
 rtl/rf_write_arbiter_if.sv | 41 ++++
 rtl/rf_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: two writeback requesters,
// the registered write port, hazard query and status.
interface rf_write_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
);
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              we3;
   logic [ADDR_W-1:0] wa3;
   logic [DATA_W-1:0] wd3;
   logic [ADDR_W-1:0] q_addr;
   logic              q_hit;
   logic [CNT_W-1:0]  drop_cnt;
   logic              busy;

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      output q_addr,
      input  a_ready, b_ready,
      input  we3, wa3, wd3,
      input  q_hit, drop_cnt, busy
   );

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      input  q_addr,
      output a_ready, b_ready,
      output we3, wa3, wd3,
      output q_hit, drop_cnt, busy
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback,
// age-ordered with round-robin tie-break; r0 writes are absorbed.
module rf_write_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
) (
   input logic               clk,
   input logic               rst_n,
   rf_write_arbiter_if.slave bus
);

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } gnt_e;

   logic              a_full_q, a_full_d;
   logic              b_full_q, b_full_d;
   logic              a_old_q, a_old_d;
   logic              b_old_q, b_old_d;
   logic [ADDR_W-1:0] a_addr_q, a_addr_d;
   logic [ADDR_W-1:0] b_addr_q, b_addr_d;
   logic [DATA_W-1:0] a_data_q, a_data_d;
   logic [DATA_W-1:0] b_data_q, b_data_d;
   logic              we3_q, we3_d;
   logic [ADDR_W-1:0] wa3_q, wa3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;
   gnt_e              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              grant_a, grant_b;
   logic              a_hs, b_hs;
   logic              a_load, b_load;
   logic              a_drop, b_drop;
   logic              a_stay, b_stay;
   logic [CNT_W:0]    cnt_sum;

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      unique case (1'b1)
         (a_full_q && !b_full_q): grant_a = 1'b1;
         (b_full_q && !a_full_q): grant_b = 1'b1;
         (a_full_q && b_full_q): begin
            if (a_old_q && !b_old_q)
               grant_a = 1'b1;
            else if (b_old_q && !a_old_q)
               grant_b = 1'b1;
            else if (last_q == GNT_B)
               grant_a = 1'b1;
            else
               grant_b = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.a_ready = !a_full_q | grant_a;
   assign bus.b_ready = !b_full_q | grant_b;

   assign a_hs   = bus.a_valid & bus.a_ready;
   assign b_hs   = bus.b_valid & bus.b_ready;
   assign a_drop = a_hs & (bus.a_addr == '0);
   assign b_drop = b_hs & (bus.b_addr == '0);
   assign a_load = a_hs & (bus.a_addr != '0);
   assign b_load = b_hs & (bus.b_addr != '0);
   assign a_stay = a_full_q & !grant_a;
   assign b_stay = b_full_q & !grant_b;

   assign cnt_sum = {1'b0, cnt_q}
                  + {{CNT_W{1'b0}}, a_drop}
                  + {{CNT_W{1'b0}}, b_drop};

   always_comb begin
      a_full_d = a_stay | a_load;
      b_full_d = b_stay | b_load;
      a_addr_d = a_load ? bus.a_addr : a_addr_q;
      a_data_d = a_load ? bus.a_data : a_data_q;
      b_addr_d = b_load ? bus.b_addr : b_addr_q;
      b_data_d = b_load ? bus.b_data : b_data_q;
      a_old_d  = 1'b0;
      b_old_d  = 1'b0;
      // The entry that stays while the other one fills becomes the elder
      unique case (1'b1)
         (a_stay && b_stay): begin
            a_old_d = a_old_q;
            b_old_d = b_old_q;
         end
         (a_stay && b_load): a_old_d = 1'b1;
         (b_stay && a_load): b_old_d = 1'b1;
         default: ;
      endcase
      we3_d  = grant_a | grant_b;
      wa3_d  = wa3_q;
      wd3_d  = wd3_q;
      last_d = last_q;
      if (grant_a) begin
         wa3_d  = a_addr_q;
         wd3_d  = a_data_q;
         last_d = GNT_A;
      end else if (grant_b) begin
         wa3_d  = b_addr_q;
         wd3_d  = b_data_q;
         last_d = GNT_B;
      end
      cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_old_q  <= 1'b0;
         b_old_q  <= 1'b0;
         a_addr_q <= '0;
         a_data_q <= '0;
         b_addr_q <= '0;
         b_data_q <= '0;
         we3_q    <= 1'b0;
         wa3_q    <= '0;
         wd3_q    <= '0;
         last_q   <= GNT_B;
         cnt_q    <= '0;
      end else begin
         a_full_q <= a_full_d;
         b_full_q <= b_full_d;
         a_old_q  <= a_old_d;
         b_old_q  <= b_old_d;
         a_addr_q <= a_addr_d;
         a_data_q <= a_data_d;
         b_addr_q <= b_addr_d;
         b_data_q <= b_data_d;
         we3_q    <= we3_d;
         wa3_q    <= wa3_d;
         wd3_q    <= wd3_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.we3      = we3_q;
   assign bus.wa3      = wa3_q;
   assign bus.wd3      = wd3_q;
   assign bus.drop_cnt = cnt_q;
   assign bus.busy     = a_full_q | b_full_q | we3_q;

   assign bus.q_hit = (bus.q_addr != '0) &
                      ((a_full_q & (a_addr_q == bus.q_addr)) |
                       (b_full_q & (b_addr_q == bus.q_addr)) |
                       (we3_q & (wa3_q == bus.q_addr)));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: accepted writes are queued
// in expected order and matched against the registered write port.
module tb_rf_write_arbiter;

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   wr_t  exp_q[$];
   wr_t  mon_e;
   logic [7:0] rf_model [8];

   rf_write_arbiter_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(8)) bus ();

   rf_write_arbiter #(.DATA_W(8), .ADDR_W(3), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every write issued on the port must be the oldest expected one
   always begin
      @(posedge clk);
      #1;
      if (bus.we3 === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write wa3=%0d wd3=%h expected none",
                     bus.wa3, bus.wd3);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.wa3 !== mon_e.addr || bus.wd3 !== mon_e.data) begin
               errors++;
               $display("FAIL write_order wa3=%0d wd3=%h expected %0d %h",
                        bus.wa3, bus.wd3, mon_e.addr, mon_e.data);
            end
         end
         rf_model[bus.wa3] = bus.wd3;
      end
   end

   task automatic push(input logic [2:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic idle_inputs();
      bus.a_valid = 1'b0;
      bus.a_addr  = '0;
      bus.a_data  = '0;
      bus.b_valid = 1'b0;
      bus.b_addr  = '0;
      bus.b_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      bus.q_addr = '0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain pending=%0d expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (bus.we3 !== 1'b0 || bus.wa3 !== 3'd0 || bus.wd3 !== 8'h00) begin
         errors++;
         $display("FAIL reset_port we3=%b wa3=%0d wd3=%h expected 0 0 00",
                  bus.we3, bus.wa3, bus.wd3);
      end
      checks++;
      if (bus.drop_cnt !== 8'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_status drop=%0d busy=%b expected 0 0",
                  bus.drop_cnt, bus.busy);
      end
      checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready a=%b b=%b expected 1 1",
                  bus.a_ready, bus.b_ready);
      end
   endtask

   task automatic test_single();
      bus.a_valid = 1'b1;
      bus.a_addr  = 3'd3;
      bus.a_data  = 8'h5A;
      bus.q_addr  = 3'd3;
      #1;
      checks++;
      if (bus.a_ready !== 1'b1 || bus.q_hit !== 1'b0) begin
         errors++;
         $display("FAIL single_pre ready=%b hit=%b expected 1 0",
                  bus.a_ready, bus.q_hit);
      end
      push(3'd3, 8'h5A);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (bus.q_hit !== 1'b1 || bus.we3 !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_buffered hit=%b we3=%b busy=%b expected 1 0 1",
                  bus.q_hit, bus.we3, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.we3 !== 1'b1 || bus.wa3 !== 3'd3 || bus.wd3 !== 8'h5A ||
          bus.q_hit !== 1'b1) begin
         errors++;
         $display("FAIL single_write we3=%b wa3=%0d wd3=%h hit=%b expected 1 3 5a 1",
                  bus.we3, bus.wa3, bus.wd3, bus.q_hit);
      end
      @(negedge clk);
      checks++;
      if (bus.we3 !== 1'b0 || bus.q_hit !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done we3=%b hit=%b busy=%b expected 0 0 0",
                  bus.we3, bus.q_hit, bus.busy);
      end
      check_drained("single");
   endtask

   task automatic test_simultaneous();
      int ia;
      int ib;
      do_reset();
      bus.a_valid = 1'b1;
      bus.a_addr  = 3'd2;
      bus.a_data  = 8'h11;
      bus.b_valid = 1'b1;
      bus.b_addr  = 3'd5;
      bus.b_data  = 8'h22;
      push(3'd2, 8'h11);
      push(3'd5, 8'h22);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.we3 !== 1'b1 || bus.wa3 !== 3'd2 || bus.wd3 !== 8'h11) begin
         errors++;
         $display("FAIL tie_first we3=%b wa3=%0d wd3=%h expected 1 2 11",
                  bus.we3, bus.wa3, bus.wd3);
      end
      @(negedge clk);
      checks++;
      if (bus.we3 !== 1'b1 || bus.wa3 !== 3'd5 || bus.wd3 !== 8'h22) begin
         errors++;
         $display("FAIL tie_second we3=%b wa3=%0d wd3=%h expected 1 5 22",
                  bus.we3, bus.wa3, bus.wd3);
      end
      @(negedge clk);
      ia = 0;
      ib = 0;
      for (int cyc = 0; cyc < 40 && (ia < 8 || ib < 8); cyc++) begin
         bus.a_valid = (ia < 8);
         bus.a_addr  = 3'(1 + ia % 7);
         bus.a_data  = 8'(8'h80 + ia);
         bus.b_valid = (ib < 8);
         bus.b_addr  = 3'(7 - ib % 7);
         bus.b_data  = 8'(8'hC0 + ib);
         #1;
         if (ia < 8 && ib < 8) begin
            checks++;
            if (bus.a_ready !== 1'b1 && bus.b_ready !== 1'b1) begin
               errors++;
               $display("FAIL stream_stall cyc=%0d a_ready=%b b_ready=%b expected one high",
                        cyc, bus.a_ready, bus.b_ready);
            end
         end
         if (bus.a_valid && bus.a_ready === 1'b1) begin
            push(bus.a_addr, bus.a_data);
            ia++;
         end
         if (bus.b_valid && bus.b_ready === 1'b1) begin
            push(bus.b_addr, bus.b_data);
            ib++;
         end
         @(negedge clk);
      end
      idle_inputs();
      repeat (4) @(negedge clk);
      checks++;
      if (ia != 8 || ib != 8) begin
         errors++;
         $display("FAIL stream_accept a=%0d b=%0d expected 8 8", ia, ib);
      end
      check_drained("stream");
   endtask

   task automatic test_same_addr();
      do_reset();
      bus.b_valid = 1'b1;
      bus.b_addr  = 3'd4;
      bus.b_data  = 8'h33;
      push(3'd4, 8'h33);
      @(negedge clk);
      bus.b_valid = 1'b0;
      bus.a_valid = 1'b1;
      bus.a_addr  = 3'd4;
      bus.a_data  = 8'h44;
      #1;
      checks++;
      if (bus.a_ready !== 1'b1) begin
         errors++;
         $display("FAIL same_ready a_ready=%b expected 1", bus.a_ready);
      end
      push(3'd4, 8'h44);
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
      checks++;
      if (rf_model[4] !== 8'h44) begin
         errors++;
         $display("FAIL same_final r4=%h expected 44", rf_model[4]);
      end
      check_drained("same");
   endtask

   task automatic test_r0();
      do_reset();
      bus.a_valid = 1'b1;
      bus.a_addr  = 3'd0;
      bus.a_data  = 8'hFF;
      bus.q_addr  = 3'd0;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (bus.drop_cnt !== 8'd10) begin
         errors++;
         $display("FAIL r0_count drop=%0d expected 10", bus.drop_cnt);
      end
      repeat (290) @(negedge clk);
      #1;
      checks++;
      if (bus.drop_cnt !== 8'd255) begin
         errors++;
         $display("FAIL r0_saturate drop=%0d expected 255", bus.drop_cnt);
      end
      checks++;
      if (bus.q_hit !== 1'b0 || bus.busy !== 1'b0 || bus.a_ready !== 1'b1) begin
         errors++;
         $display("FAIL r0_state hit=%b busy=%b ready=%b expected 0 0 1",
                  bus.q_hit, bus.busy, bus.a_ready);
      end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_midreset();
      do_reset();
      bus.a_valid = 1'b1;
      bus.a_addr  = 3'd1;
      bus.a_data  = 8'hA1;
      bus.b_valid = 1'b1;
      bus.b_addr  = 3'd6;
      bus.b_data  = 8'hB6;
      push(3'd1, 8'hA1);
      push(3'd6, 8'hB6);
      @(negedge clk);
      bus.b_valid = 1'b0;
      bus.a_addr  = 3'd7;
      bus.a_data  = 8'hA7;
      #1;
      checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_ready a=%b b=%b expected 1 0",
                  bus.a_ready, bus.b_ready);
      end
      push(3'd7, 8'hA7);
      @(negedge clk);
      idle_inputs();
      bus.q_addr = 3'd6;
      #1;
      checks++;
      if (bus.we3 !== 1'b1 || bus.wa3 !== 3'd1 || bus.q_hit !== 1'b1) begin
         errors++;
         $display("FAIL mid_loaded we3=%b wa3=%0d hit=%b expected 1 1 1",
                  bus.we3, bus.wa3, bus.q_hit);
      end
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (bus.we3 !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_flush we3=%b busy=%b expected 0 0",
                  bus.we3, bus.busy);
      end
      for (int q = 0; q < 8; q++) begin
         bus.q_addr = 3'(q);
         #1;
         checks++;
         if (bus.q_hit !== 1'b0) begin
            errors++;
            $display("FAIL mid_hit q_addr=%0d hit=%b expected 0", q, bus.q_hit);
         end
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bus.a_valid = 1'b1;
      bus.a_addr  = 3'd2;
      bus.a_data  = 8'h12;
      bus.b_valid = 1'b1;
      bus.b_addr  = 3'd3;
      bus.b_data  = 8'h13;
      push(3'd2, 8'h12);
      push(3'd3, 8'h13);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.we3 !== 1'b1 || bus.wa3 !== 3'd2 || bus.wd3 !== 8'h12) begin
         errors++;
         $display("FAIL mid_tie we3=%b wa3=%0d wd3=%h expected 1 2 12",
                  bus.we3, bus.wa3, bus.wd3);
      end
      repeat (3) @(negedge clk);
      check_drained("mid");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      for (int r = 0; r < 8; r++) rf_model[r] = 8'h00;
      idle_inputs();
      bus.q_addr = '0;
      test_reset();
      test_single();
      test_simultaneous();
      test_same_addr();
      test_r0();
      test_midreset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
